i2c_tx_dbuf_ctrl: RTL
=====================

Name: i2c_tx_dbuf_ctrl

Overview:
Sequencer that drives the I2C TX pin interface (i2cTXinterface) from a host-side double byte buffer. It accepts bytes from the host into two 8-bit buffers (buf0/buf1). For each write transaction it issues the strobe sequence START, address, write bit, ACK, then per byte DATA and ACK, then STOP. Buffers ping-pong so the host can refill one while the other shifts.

Parameters:
CLKS_PER_BIT, 8, clk cycles each bit, START and STOP phase is held
ACK_TIMEOUT, 64, clk cycles to wait for RecvdAck before declaring NACK

Ports:
clk  in  1  system clock
rst  in  1  reset
wr_en  in  1  host byte write strobe
wr_data  in  8  host byte
buf_full  out  1  both buffers valid; wr_en ignored
start_xfer  in  1  start a transaction (pulse)
slave_addr  in  7  target address, latched at start_xfer
byte_count  in  8  bytes to send, latched at start_xfer; 0 = address-only
busy  out  1  transaction in progress
done  out  1  1-cycle pulse on leaving STOP
nack_err  out  1  sticky; cleared by next accepted start_xfer
SendStartSig  out  1  to TX interface
SendWriteSig  out  1  to TX interface (R/W bit = 0)
SendStopSig  out  1  to TX interface
WaitAck  out  1  to TX interface
RecvdAck  in  1  from TX interface
ShiftTXBuf0  out  1  shifting address or buf0 bit
ShiftTXBuf1  out  1  shifting buf1 bit
data  out  1  current serial bit

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs 0, both buffer valid flags 0, wr_ptr = rd_ptr = 0, FSM IDLE, bit/tick counters 0. Reset mid-transaction aborts immediately, with no STOP issued.
- All outputs are registered. At most one of SendStartSig, SendWriteSig, SendStopSig, WaitAck, ShiftTXBuf0, ShiftTXBuf1 is high in any cycle.
- Host buffer:
  - wr_en && !buf_full writes buf[wr_ptr], sets its valid flag and toggles wr_ptr.
  - A buffer is released (valid cleared, rd_ptr toggled) in the cycle its 8th bit period ends.
  - Release and write in the same cycle are both honoured.
  - buf_full = valid0 && valid1.
- tick: counter 0..CLKS_PER_BIT-1. Each phase (START bit, STOP bit, each address/data/write bit) lasts exactly CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE: start_xfer accepted → START. busy rises the next cycle; nack_err cleared; slave_addr and byte_count latched into remaining.
  - START: SendStartSig held one bit period → ADDR.
  - ADDR: ShiftTXBuf0=1; data = slave_addr MSB first, 7 bit periods → WRBIT.
  - WRBIT: SendWriteSig one bit period → ACK.
  - ACK: WaitAck=1.
    - RecvdAck=1 → WaitAck drops next cycle. If remaining==0 → STOP; else if valid[rd_ptr] → DATA; else → HOLD.
    - ACK_TIMEOUT cycles without RecvdAck → nack_err=1 → STOP.
  - HOLD: all strobes 0; wait for valid[rd_ptr] → DATA.
  - DATA: ShiftTXBuf0 if rd_ptr==0, else ShiftTXBuf1; data = buf[rd_ptr] MSB first, 8 bit periods. At end: release buffer, remaining−1 → ACK.
  - STOP: SendStopSig one bit period → IDLE with done=1 for 1 cycle; busy falls the same cycle.
- start_xfer while busy is ignored.
- Host writes are accepted in any state, including IDLE (pre-load).
- Timeout counter resets on each entry to ACK.

Decomposition:
- Shared package i2c_pkg: FSM state enum (IDLE, START, ADDR, WRBIT, ACK, HOLD, DATA, STOP), I2C_WRITE_BIT=0, address width 7, byte width 8.
- One sub-module: i2c_tx_dbuf (two buffers, valid flags, wr/rd pointers, buf_full). The FSM stays in i2c_tx_dbuf_ctrl.

Test Plan:
- Pre-load 0xA5, 0x3C; start_xfer, addr=0x50, count=2; RecvdAck=1 on each WaitAck → START, bits 1010000, write bit, ACK, 10100101 on ShiftTXBuf0, ACK, 00111100 on ShiftTXBuf1, ACK, STOP; done pulse; nack_err=0.
- count=0, addr=0x7F → START, 1111111, write bit, ACK, STOP; no ShiftTXBuf1 strobe.
- count=3 with only 1 byte pre-loaded → HOLD after second ACK with all strobes 0; write 0x01 at an arbitrary later cycle → resumes DATA, shifting 00000001.
- RecvdAck held 0 → WaitAck high for exactly ACK_TIMEOUT cycles, then STOP; nack_err=1 until next start_xfer.
- Three wr_en with no transaction → buf_full=1 after second; third byte dropped; sending later yields first two bytes only.
- Assert rst mid-DATA → next cycle all outputs 0, busy=0, buf_full=0; new transaction starts cleanly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C TX double-buffer sequencer.
package i2c_pkg;
  localparam int   ADDR_W        = 7;
  localparam int   BYTE_W        = 8;
  localparam logic I2C_WRITE_BIT = 1'b0;

  typedef enum logic [2:0] {
    IDLE, START, ADDR, WRBIT, ACK, HOLD, DATA, STOP
  } state_t;
endpackage

// File: rtl/i2c_tx_dbuf.sv
// Two-entry ping-pong byte buffer: the host fills one slot while the other shifts out.
module i2c_tx_dbuf
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rel,
  output logic              buf_full,
  output logic              valid_rd,
  output logic              rd_sel,
  output logic [BYTE_W-1:0] rd_data
);
  logic [BYTE_W-1:0] mem [2];
  logic [1:0]        valid;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              wr_ok;

  assign wr_ok = wr_en && !buf_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 2'b00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      // A write targets the empty slot and a release the full one, so both may land together.
      if (wr_ok) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= ~wr_ptr;
      end
      if (rel) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= ~rd_ptr;
      end
    end
  end

  // NOTE: the byte storage is deliberately not reset; the valid flags decide whether it is read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  assign buf_full = &valid;
  assign valid_rd = valid[rd_ptr];
  assign rd_sel   = rd_ptr;
  assign rd_data  = mem[rd_ptr];
endmodule

// File: rtl/i2c_tx_dbuf_ctrl.sv
// I2C write-transaction sequencer: START, address, W bit, ACK, {DATA, ACK}*, STOP,
// fed from a host double buffer. Every output is a register updated with the state.
module i2c_tx_dbuf_ctrl
  import i2c_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              buf_full,
  input  logic              start_xfer,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic [7:0]        byte_count,
  output logic              busy,
  output logic              done,
  output logic              nack_err,
  output logic              SendStartSig,
  output logic              SendWriteSig,
  output logic              SendStopSig,
  output logic              WaitAck,
  input  logic              RecvdAck,
  output logic              ShiftTXBuf0,
  output logic              ShiftTXBuf1,
  output logic              data
);
  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [2:0]        bit_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [BYTE_W-1:0] sh;
  logic [ADDR_W-1:0] addr_lat;
  logic [7:0]        remaining;

  logic              phase_end;
  logic              rel;
  logic              valid_rd;
  logic              rd_sel;
  logic [BYTE_W-1:0] rd_data;

  assign phase_end = (tick == TICK_W'(CLKS_PER_BIT - 1));
  assign rel       = (state == DATA) && phase_end && (bit_cnt == 3'd7);

  i2c_tx_dbuf u_dbuf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rel      (rel),
    .buf_full (buf_full),
    .valid_rd (valid_rd),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data)
  );

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tick         <= '0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      sh           <= '0;
      addr_lat     <= '0;
      remaining    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      nack_err     <= 1'b0;
      SendStartSig <= 1'b0;
      SendWriteSig <= 1'b0;
      SendStopSig  <= 1'b0;
      WaitAck      <= 1'b0;
      ShiftTXBuf0  <= 1'b0;
      ShiftTXBuf1  <= 1'b0;
      data         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_xfer) begin
            state        <= START;
            busy         <= 1'b1;
            nack_err     <= 1'b0;
            addr_lat     <= slave_addr;
            remaining    <= byte_count;
            tick         <= '0;
            SendStartSig <= 1'b1;
          end
        end

        START: begin
          if (phase_end) begin
            tick         <= '0;
            SendStartSig <= 1'b0;
            ShiftTXBuf0  <= 1'b1;
            data         <= addr_lat[ADDR_W-1];
            sh           <= {addr_lat[ADDR_W-2:0], 2'b00};
            bit_cnt      <= '0;
            state        <= ADDR;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end

        ADDR: begin
          if (phase_end) begin
            tick <= '0;
            if (bit_cnt == 3'd6) begin
              ShiftTXBuf0  <= 1'b0;
              SendWriteSig <= 1'b1;
              data         <= I2C_WRITE_BIT;
              state        <= WRBIT;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              data    <= sh[BYTE_W-1];
              sh      <= {sh[BYTE_W-2:0], 1'b0};
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end

        WRBIT: begin
          if (phase_end) begin
            tick         <= '0;
            SendWriteSig <= 1'b0;
            WaitAck      <= 1'b1;
            to_cnt       <= '0;
            data         <= 1'b0;
            state        <= ACK;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end

        ACK: begin
          if (RecvdAck) begin
            WaitAck <= 1'b0;
            if (remaining == 8'd0) begin
              SendStopSig <= 1'b1;
              tick        <= '0;
              state       <= STOP;
            end else if (valid_rd) begin
              ShiftTXBuf0 <= ~rd_sel;
              ShiftTXBuf1 <= rd_sel;
              data        <= rd_data[BYTE_W-1];
              sh          <= {rd_data[BYTE_W-2:0], 1'b0};
              bit_cnt     <= '0;
              tick        <= '0;
              state       <= DATA;
            end else begin
              state <= HOLD;
            end
          end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            WaitAck     <= 1'b0;
            nack_err    <= 1'b1;
            SendStopSig <= 1'b1;
            tick        <= '0;
            state       <= STOP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        HOLD: begin
          if (valid_rd) begin
            ShiftTXBuf0 <= ~rd_sel;
            ShiftTXBuf1 <= rd_sel;
            data        <= rd_data[BYTE_W-1];
            sh          <= {rd_data[BYTE_W-2:0], 1'b0};
            bit_cnt     <= '0;
            tick        <= '0;
            state       <= DATA;
          end
        end

        DATA: begin
          if (phase_end) begin
            tick <= '0;
            if (bit_cnt == 3'd7) begin
              ShiftTXBuf0 <= 1'b0;
              ShiftTXBuf1 <= 1'b0;
              data        <= 1'b0;
              remaining   <= remaining - 8'd1;
              WaitAck     <= 1'b1;
              to_cnt      <= '0;
              state       <= ACK;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              data    <= sh[BYTE_W-1];
              sh      <= {sh[BYTE_W-2:0], 1'b0};
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end

        STOP: begin
          if (phase_end) begin
            tick        <= '0;
            SendStopSig <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= IDLE;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
